// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit and its buffers.
package fetch_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t inst;
    word_t pc;
  } fetch_entry_t;

  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Generic in-order FIFO with synchronous flush; count output drives credit accounting.
// Latency: push visible at the head the cycle after the push edge; no bypass.
// Backpressure: none internally; callers must never push when full (unless popping) or pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flush wins over any same-cycle push or pop.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && count == CNT_W'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(do_pop && count == '0));

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues sequential word fetches, buffers responses for decode, flushes on redirect.
// Latency: response to inst_valid is 1 cycle (registered buffer). Optional counters via FETCH_PERF_CNT_EN.
// Backpressure: requests gated by credits (in-flight + buffered < BUF_DEPTH); inst_ready stalls via credits.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC  = DEFAULT_RESET_PC,
  parameter int    BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stale_drops
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  word_t            pc_q;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] stale_cnt;
  logic [CNT_W-1:0] ibuf_count;
  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             resp_drop;
  logic             ibuf_push;
  logic             ibuf_pop;
  word_t            resp_pc;
  fetch_entry_t     ibuf_in;
  fetch_entry_t     ibuf_head;

  // Credit pool covers both in-flight requests and buffered instructions.
  assign credit_used    = {1'b0, out_cnt} + {1'b0, ibuf_count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CNT_W+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = redirect_valid || (stale_cnt != '0);
  assign ibuf_push = imem_resp_valid && !resp_drop;
  assign ibuf_in   = '{inst: imem_resp_data, pc: resp_pc};

  assign inst_valid = !rst && (ibuf_count != '0) && !redirect_valid;
  assign ibuf_pop   = inst_valid && inst_ready;
  assign inst       = ibuf_head.inst;
  assign inst_pc    = ibuf_head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_target;
    end else if (req_fire) begin
      pc_q <= pc_q + 32'd1;
    end
  end

  // Responses still owed to pre-redirect requests; the coincident response is already dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      stale_cnt <= '0;
    end else if (redirect_valid) begin
      stale_cnt <= out_cnt - CNT_W'(imem_resp_valid);
    end else if (imem_resp_valid && (stale_cnt != '0)) begin
      stale_cnt <= stale_cnt - CNT_W'(1);
    end
  end

  // The PC queue is never flushed: every accepted request, stale or not, retires one entry
  // on its response, so its occupancy is exactly the in-flight count.
  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(word_t))
  ) u_pc_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (1'b0),
    .push     (req_fire),
    .push_dat (pc_q),
    .pop      (imem_resp_valid),
    .pop_dat  (resp_pc),
    .count    (out_cnt)
  );

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (ibuf_push),
    .push_dat (ibuf_in),
    .pop      (ibuf_pop),
    .pop_dat  (ibuf_head),
    .count    (ibuf_count)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects   <= '0;
      perf_stale_drops <= '0;
    end else begin
      if (redirect_valid)              perf_redirects   <= perf_redirects + 32'd1;
      if (imem_resp_valid && resp_drop) perf_stale_drops <= perf_stale_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: in-order memory model plus an expected-PC-stream reference.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam word_t RST_PC = 32'h0000_0100;
  localparam int    DEPTH  = 2;

  logic  clk;
  logic  rst;
  logic  redirect_valid;
  word_t redirect_target;
  logic  imem_req_valid;
  word_t imem_req_addr;
  logic  imem_req_ready;
  logic  imem_resp_valid;
  word_t imem_resp_data;
  logic  inst_valid;
  word_t inst;
  word_t inst_pc;
  logic  inst_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stale_drops;
`endif

  fetch_pc_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects  (perf_redirects),
    .perf_stale_drops(perf_stale_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic  n_rst, n_redir, n_req_rdy, n_inst_rdy;
  word_t n_tgt;
  word_t mq_addr[$];
  int    mq_due[$];
  int    fires, resps, delivs, pre_fires, pre_resps, pre_delivs;
  logic  o_req_vld, o_req_fire, o_inst_vld, o_pop;
  word_t o_req_addr, o_inst, o_inst_pc;

  function automatic word_t mem_word(input word_t a);
    return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: apply inputs and memory response, sample outputs, advance the memory model.
  task automatic cycle();
    @(negedge clk);
    pre_fires = fires; pre_resps = resps; pre_delivs = delivs;
    rst = n_rst; redirect_valid = n_redir; redirect_target = n_tgt;
    imem_req_ready = n_req_rdy; inst_ready = n_inst_rdy;
    if (n_rst) begin
      mq_addr.delete(); mq_due.delete();
      fires = 0; resps = 0; delivs = 0;
      imem_resp_valid = 1'b0; imem_resp_data = '0;
    end else if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
      resps++;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    o_req_vld  = imem_req_valid;  o_req_addr = imem_req_addr;
    o_req_fire = imem_req_valid && imem_req_ready;
    o_inst_vld = inst_valid; o_inst = inst; o_inst_pc = inst_pc;
    o_pop      = inst_valid && inst_ready;
    if (o_req_fire) begin
      mq_addr.push_back(o_req_addr);
      mq_due.push_back(cyc + mem_lat);
      fires++;
    end
    if (o_pop) delivs++;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    n_rst = 1'b1; n_redir = 1'b0; n_tgt = '0; n_req_rdy = 1'b1; n_inst_rdy = 1'b1;
    repeat (2) cycle();
    n_rst = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; n_redir = 1'b0; n_tgt = '0; n_req_rdy = 1'b1; n_inst_rdy = 1'b1;
    repeat (3) begin
      cycle();
      vectors++;
      if (o_req_vld !== 1'b0 || o_inst_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: req_valid=%b inst_valid=%b, expected 0 0", o_req_vld, o_inst_vld);
      end
    end
    n_rst = 1'b0;
    cycle();
    vectors++;
    if (o_req_fire !== 1'b1 || o_req_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL reset_first_req: fire=%b addr=%h, expected 1 %h", o_req_fire, o_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    word_t exp_req, exp_del;
    int first_fire, first_del;
    do_reset();
    mem_lat = 1; exp_req = RST_PC; exp_del = RST_PC; first_fire = -1; first_del = -1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      vectors++;
      if (o_req_vld !== ((pre_fires - pre_delivs) < DEPTH)) begin
        miscompares++;
        $display("FAIL stream_credit: cycle %0d req_valid=%b, in_use=%0d", k, o_req_vld, pre_fires - pre_delivs);
      end
      vectors++;
      if (o_inst_vld !== (pre_resps > pre_delivs)) begin
        miscompares++;
        $display("FAIL stream_inst_valid: cycle %0d got %b, expected %b", k, o_inst_vld, pre_resps > pre_delivs);
      end
      if (o_req_fire) begin
        vectors++;
        if (o_req_addr !== exp_req) begin
          miscompares++;
          $display("FAIL stream_req_addr: got %h, expected %h", o_req_addr, exp_req);
        end
        exp_req++;
        if (first_fire < 0) first_fire = k;
      end
      if (o_pop) begin
        vectors++;
        if (o_inst_pc !== exp_del || o_inst !== mem_word(exp_del)) begin
          miscompares++;
          $display("FAIL stream_deliver: pc=%h inst=%h, expected %h %h", o_inst_pc, o_inst, exp_del, mem_word(exp_del));
        end
        exp_del++;
        if (first_del < 0) first_del = k;
      end
    end
    vectors++;
    if (first_fire != 0 || first_del != 2 || (exp_del - RST_PC) < 8) begin
      miscompares++;
      $display("FAIL stream_latency: first req %0d first inst %0d count %0d, expected 0 2 >=8",
               first_fire, first_del, exp_del - RST_PC);
    end
  endtask

  task automatic test_redirect_inflight();
    int got;
    logic seen_fire, seen_del;
    do_reset();
    mem_lat = 3;
    n_redir = 1'b1; n_tgt = 32'h0;
    cycle();
    n_redir = 1'b0; got = 0;
    for (int k = 0; k < 10 && got < 2; k++) begin
      cycle();
      if (o_req_fire) begin
        vectors++;
        if (o_req_addr !== word_t'(got)) begin
          miscompares++;
          $display("FAIL inflight_req: got %h, expected %h", o_req_addr, got);
        end
        got++;
      end
    end
    vectors++;
    if (got != 2) begin
      miscompares++;
      $display("FAIL inflight_timeout: %0d requests accepted, expected 2", got);
    end
    n_redir = 1'b1; n_tgt = 32'h40;
    cycle();
    vectors++;
    if (o_req_vld !== 1'b0 || o_inst_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_redirect_cycle: req_valid=%b inst_valid=%b, expected 0 0", o_req_vld, o_inst_vld);
    end
    n_redir = 1'b0; seen_fire = 1'b0; seen_del = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (o_req_fire && !seen_fire) begin
        seen_fire = 1'b1; vectors++;
        if (o_req_addr !== 32'h40) begin
          miscompares++;
          $display("FAIL inflight_first_req: got %h, expected 00000040", o_req_addr);
        end
      end
      if (o_pop && !seen_del) begin
        seen_del = 1'b1; vectors++;
        if (o_inst_pc !== 32'h40 || o_inst !== mem_word(32'h40)) begin
          miscompares++;
          $display("FAIL inflight_first_inst: pc=%h inst=%h, expected 00000040 %h", o_inst_pc, o_inst, mem_word(32'h40));
        end
      end
    end
    vectors++;
    if (!seen_del) begin
      miscompares++;
      $display("FAIL inflight_no_delivery: got none, expected pc 00000040");
    end
  endtask

  task automatic test_backpressure();
    word_t exp_del;
    int n_fire;
    do_reset();
    mem_lat = 1; n_inst_rdy = 1'b0; n_fire = 0;
    repeat (10) begin
      cycle();
      if (o_req_fire) n_fire++;
    end
    vectors++;
    if (n_fire != DEPTH || o_req_vld !== 1'b0 || o_inst_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stall: requests=%0d req_valid=%b inst_valid=%b, expected %0d 0 1",
               n_fire, o_req_vld, o_inst_vld, DEPTH);
    end
    n_inst_rdy = 1'b1; exp_del = RST_PC;
    repeat (12) begin
      cycle();
      if (o_req_fire) begin
        vectors++;
        if (o_req_addr !== RST_PC + word_t'(n_fire)) begin
          miscompares++;
          $display("FAIL bp_resume_req: got %h, expected %h", o_req_addr, RST_PC + word_t'(n_fire));
        end
        n_fire++;
      end
      if (o_pop) begin
        vectors++;
        if (o_inst_pc !== exp_del || o_inst !== mem_word(exp_del)) begin
          miscompares++;
          $display("FAIL bp_resume_inst: pc=%h, expected %h", o_inst_pc, exp_del);
        end
        exp_del++;
      end
    end
    vectors++;
    if ((exp_del - RST_PC) < 6) begin
      miscompares++;
      $display("FAIL bp_resume_count: delivered %0d, expected >=6", exp_del - RST_PC);
    end
  endtask

  task automatic test_coincident();
    logic seen_del;
    do_reset();
    mem_lat = 2;
    cycle();
    n_req_rdy = 1'b0;
    cycle();
    n_redir = 1'b1; n_tgt = 32'h200; n_req_rdy = 1'b1;
    cycle();
    vectors++;
    if (o_req_vld !== 1'b0 || imem_resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL coinc_redirect_cycle: req_valid=%b resp_valid=%b, expected 0 1", o_req_vld, imem_resp_valid);
    end
    n_redir = 1'b0;
    cycle();
    vectors++;
    if (o_req_fire !== 1'b1 || o_req_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL coinc_next_req: fire=%b addr=%h, expected 1 00000200", o_req_fire, o_req_addr);
    end
    seen_del = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (o_pop && !seen_del) begin
        seen_del = 1'b1; vectors++;
        if (o_inst_pc !== 32'h200 || o_inst !== mem_word(32'h200)) begin
          miscompares++;
          $display("FAIL coinc_first_inst: pc=%h, expected 00000200", o_inst_pc);
        end
      end
    end
    vectors++;
    if (!seen_del) begin
      miscompares++;
      $display("FAIL coinc_no_delivery: got none, expected pc 00000200");
    end
  endtask

  task automatic test_wrap();
    word_t exp_del;
    do_reset();
    mem_lat = 1;
    n_redir = 1'b1; n_tgt = 32'hFFFF_FFFF;
    cycle();
    n_redir = 1'b0; n_req_rdy = 1'b0;
    repeat (3) begin
      cycle();
      vectors++;
      if (o_req_vld !== 1'b1 || o_req_addr !== 32'hFFFF_FFFF) begin
        miscompares++;
        $display("FAIL wrap_hold: valid=%b addr=%h, expected 1 ffffffff", o_req_vld, o_req_addr);
      end
    end
    n_req_rdy = 1'b1;
    cycle();
    vectors++;
    if (o_req_fire !== 1'b1 || o_req_addr !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_accept: fire=%b addr=%h, expected 1 ffffffff", o_req_fire, o_req_addr);
    end
    cycle();
    vectors++;
    if (o_req_fire !== 1'b1 || o_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next: fire=%b addr=%h, expected 1 00000000", o_req_fire, o_req_addr);
    end
    exp_del = 32'hFFFF_FFFF;
    repeat (6) begin
      cycle();
      if (o_pop) begin
        vectors++;
        if (o_inst_pc !== exp_del || o_inst !== mem_word(exp_del)) begin
          miscompares++;
          $display("FAIL wrap_inst: pc=%h, expected %h", o_inst_pc, exp_del);
        end
        exp_del++;
      end
    end
  endtask

  task automatic test_random();
    word_t exp_req, exp_del;
    int n_del;
    do_reset();
    exp_req = RST_PC; exp_del = RST_PC; n_del = 0;
    for (int k = 0; k < 600; k++) begin
      n_redir    = ($urandom_range(0, 9) == 0);
      n_tgt      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : word_t'($urandom);
      n_req_rdy  = ($urandom_range(0, 3) != 0);
      n_inst_rdy = ($urandom_range(0, 2) != 0);
      mem_lat    = $urandom_range(1, 4);
      cycle();
      vectors++;
      if ((pre_fires - pre_resps) > DEPTH) begin
        miscompares++;
        $display("FAIL rand_inflight: %0d outstanding, limit %0d", pre_fires - pre_resps, DEPTH);
      end
      if (n_redir) begin
        vectors++;
        if (o_req_vld !== 1'b0 || o_inst_vld !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_redirect: req_valid=%b inst_valid=%b, expected 0 0", o_req_vld, o_inst_vld);
        end
        exp_req = n_tgt; exp_del = n_tgt;
      end else begin
        if (o_req_fire) begin
          vectors++;
          if (o_req_addr !== exp_req) begin
            miscompares++;
            $display("FAIL rand_req: got %h, expected %h", o_req_addr, exp_req);
          end
          exp_req++;
        end
        if (o_pop) begin
          vectors++;
          if (o_inst_pc !== exp_del || o_inst !== mem_word(exp_del)) begin
            miscompares++;
            $display("FAIL rand_inst: pc=%h inst=%h, expected %h %h", o_inst_pc, o_inst, exp_del, mem_word(exp_del));
          end
          exp_del++; n_del++;
        end
      end
    end
    vectors++;
    if (n_del < 50) begin
      miscompares++;
      $display("FAIL rand_progress: delivered %0d, expected >=50", n_del);
    end
    // Reset with requests still in flight.
    n_redir = 1'b0; n_rst = 1'b1;
    cycle();
    vectors++;
    if (o_req_vld !== 1'b0 || o_inst_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: req_valid=%b inst_valid=%b, expected 0 0", o_req_vld, o_inst_vld);
    end
    n_rst = 1'b0; n_req_rdy = 1'b1;
    cycle();
    vectors++;
    if (o_req_fire !== 1'b1 || o_req_addr !== RST_PC || o_inst_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_restart: fire=%b addr=%h inst_valid=%b, expected 1 %h 0",
               o_req_fire, o_req_addr, o_inst_vld, RST_PC);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    vectors++;
    if (perf_redirects !== 32'd0 || perf_stale_drops !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_reset: %0d %0d, expected 0 0", perf_redirects, perf_stale_drops);
    end
    mem_lat = 3;
    repeat (2) cycle();
    n_redir = 1'b1; n_tgt = 32'h10; cycle();
    n_redir = 1'b0; repeat (3) cycle();
    n_redir = 1'b1; n_tgt = 32'h20; cycle();
    n_tgt = 32'h30; cycle();
    n_redir = 1'b0; repeat (12) cycle();
    vectors++;
    if (perf_redirects !== 32'd3 || perf_stale_drops !== 32'd4) begin
      miscompares++;
      $display("FAIL perf_counts: redirects=%0d drops=%0d, expected 3 4", perf_redirects, perf_stale_drops);
    end
    do_reset();
    cycle();
    vectors++;
    if (perf_redirects !== 32'd0 || perf_stale_drops !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_clear: %0d %0d, expected 0 0", perf_redirects, perf_stale_drops);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
    fires = 0; resps = 0; delivs = 0;
    test_reset();
    test_stream();
    test_redirect_inflight();
    test_backpressure();
    test_coincident();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
